operand_bypass: RTL and testbench

//  Writer-side counterpart of decode hazard detection. Tracks destination tags through the E/M/WB stages.

---
 rtl/bean2_pipe_pkg.sv | 31 +++
 rtl/operand_fwd_select.sv | 53 +++++
 rtl/operand_bypass.sv | 127 ++++++++++++
 tb/tb_operand_bypass.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/bean2_pipe_pkg.sv
// rtl/bean2_pipe_pkg.sv - shared encodings and stage-tag type for the operand bypass
package bean2_pipe_pkg;

    // Register address width carried in each stage tag
    localparam int TAG_AW = 5;

    // Operand source select
    localparam logic [1:0] FWD_RF = 2'd0;
    localparam logic [1:0] FWD_E  = 2'd1;
    localparam logic [1:0] FWD_M  = 2'd2;
    localparam logic [1:0] FWD_WB = 2'd3;

    // Decode read-mask encodings
    localparam logic [1:0] RD_NONE = 2'b00;
    localparam logic [1:0] RD_RS1  = 2'b01;
    localparam logic [1:0] RD_RS2  = 2'b10;
    localparam logic [1:0] RD_BOTH = 2'b11;

    // Destination tag travelling alongside each instruction in E/M/WB
    typedef struct packed {
        logic              we;
        logic              load;
        logic [TAG_AW-1:0] rd;
    } stage_tag_t;

    // True when the read mask requests the given operand bit
    function automatic logic rd_wants(input logic [1:0] mask, input logic [1:0] which);
        return (mask & which) != RD_NONE;
    endfunction

endpackage

// File: rtl/operand_fwd_select.sv
// rtl/operand_fwd_select.sv - picks the youngest in-flight producer for one source operand
import bean2_pipe_pkg::*;

module operand_fwd_select #(
    parameter int XLEN = 32
) (
    input  logic              i_rd_en,
    input  logic [TAG_AW-1:0] i_rs,
    input  stage_tag_t        i_tag_e,
    input  stage_tag_t        i_tag_m,
    input  stage_tag_t        i_tag_wb,
    input  logic [XLEN-1:0]   i_res_e,
    input  logic [XLEN-1:0]   i_res_m,
    input  logic [XLEN-1:0]   i_res_wb,
    input  logic [XLEN-1:0]   i_rf,
    output logic [1:0]        o_sel,
    output logic [XLEN-1:0]   o_op,
    output logic              o_load_hit
);

    logic w_live;
    logic w_hit_e;
    logic w_hit_m;
    logic w_hit_wb;

    // x0 never forwards; an unread operand never matches
    assign w_live   = i_rd_en && (i_rs != '0);
    assign w_hit_e  = w_live && i_tag_e.we  && (i_tag_e.rd  == i_rs);
    assign w_hit_m  = w_live && i_tag_m.we  && (i_tag_m.rd  == i_rs);
    assign w_hit_wb = w_live && i_tag_wb.we && (i_tag_wb.rd == i_rs);

    // Youngest match wins; a load in E blocks older stages since their value is stale
    always_comb begin
        o_sel      = FWD_RF;
        o_op       = i_rf;
        o_load_hit = 1'b0;
        if (w_hit_e) begin
            if (i_tag_e.load) begin
                o_load_hit = 1'b1;
            end else begin
                o_sel = FWD_E;
                o_op  = i_res_e;
            end
        end else if (w_hit_m) begin
            o_sel = FWD_M;
            o_op  = i_res_m;
        end else if (w_hit_wb) begin
            o_sel = FWD_WB;
            o_op  = i_res_wb;
        end
    end

endmodule

// File: rtl/operand_bypass.sv
// rtl/operand_bypass.sv - E/M/WB tag tracking, operand forwarding and load-use stall; perf counters under BYPASS_PERF_EN
import bean2_pipe_pkg::*;

module operand_bypass #(
    parameter int XLEN   = 32,
    parameter int REG_AW = TAG_AW,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        reg_RD,
    input  logic [REG_AW-1:0] rs1,
    input  logic [REG_AW-1:0] rs2,
    input  logic [REG_AW-1:0] rs3,
    input  logic              reg_WE,
    input  logic              is_load,
    input  logic              flush_in,
    input  logic [XLEN-1:0]   res_E,
    input  logic [XLEN-1:0]   res_M,
    input  logic [XLEN-1:0]   res_WB,
    input  logic [XLEN-1:0]   rf_rd1,
    input  logic [XLEN-1:0]   rf_rd2,
    output logic [XLEN-1:0]   op1,
    output logic [XLEN-1:0]   op2,
    output logic [1:0]        fwd_sel1,
    output logic [1:0]        fwd_sel2,
    output logic              stall_FD,
    output logic              bubble_E,
    output logic [CNT_W-1:0]  fwd_cnt,
    output logic [CNT_W-1:0]  stall_cnt
);

    stage_tag_t        r_tag_e;
    stage_tag_t        r_tag_m;
    stage_tag_t        r_tag_wb;
    stage_tag_t        w_tag_d;
    logic [1:0]        w_sel1;
    logic [1:0]        w_sel2;
    logic [XLEN-1:0]   w_op1;
    logic [XLEN-1:0]   w_op2;
    logic              w_hit1;
    logic              w_hit2;
    logic              w_load_use;
    logic              w_bubble;

    assign w_tag_d    = '{we: reg_WE, load: is_load, rd: rs3};
    assign w_load_use = w_hit1 | w_hit2;
    assign w_bubble   = w_load_use | flush_in;

    operand_fwd_select #(.XLEN(XLEN)) u_sel1 (
        .i_rd_en   (rd_wants(reg_RD, RD_RS1)),
        .i_rs      (rs1),
        .i_tag_e   (r_tag_e),
        .i_tag_m   (r_tag_m),
        .i_tag_wb  (r_tag_wb),
        .i_res_e   (res_E),
        .i_res_m   (res_M),
        .i_res_wb  (res_WB),
        .i_rf      (rf_rd1),
        .o_sel     (w_sel1),
        .o_op      (w_op1),
        .o_load_hit(w_hit1)
    );

    operand_fwd_select #(.XLEN(XLEN)) u_sel2 (
        .i_rd_en   (rd_wants(reg_RD, RD_RS2)),
        .i_rs      (rs2),
        .i_tag_e   (r_tag_e),
        .i_tag_m   (r_tag_m),
        .i_tag_wb  (r_tag_wb),
        .i_res_e   (res_E),
        .i_res_m   (res_M),
        .i_res_wb  (res_WB),
        .i_rf      (rf_rd2),
        .o_sel     (w_sel2),
        .o_op      (w_op2),
        .o_load_hit(w_hit2)
    );

    // Outputs are forced low while reset is held so stall_FD drops the instant reset asserts
    assign fwd_sel1 = reset ? w_sel1 : FWD_RF;
    assign fwd_sel2 = reset ? w_sel2 : FWD_RF;
    assign op1      = reset ? w_op1  : '0;
    assign op2      = reset ? w_op2  : '0;
    assign stall_FD = reset & w_load_use & ~flush_in;
    assign bubble_E = reset & w_bubble;

    // Tag pipeline never stalls; a bubble enters E on load-use or flush
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tag_e  <= '0;
            r_tag_m  <= '0;
            r_tag_wb <= '0;
        end else begin
            r_tag_wb <= r_tag_m;
            r_tag_m  <= r_tag_e;
            r_tag_e  <= w_bubble ? '0 : w_tag_d;
        end
    end

`ifdef BYPASS_PERF_EN
    logic [CNT_W-1:0] r_fwd_cnt;
    logic [CNT_W-1:0] r_stall_cnt;

    // Count forwarding cycles and stall cycles; both wrap naturally
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_fwd_cnt   <= '0;
            r_stall_cnt <= '0;
        end else begin
            if ((fwd_sel1 != FWD_RF) || (fwd_sel2 != FWD_RF)) begin
                r_fwd_cnt <= r_fwd_cnt + 1'b1;
            end
            if (stall_FD) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
        end
    end

    assign fwd_cnt   = r_fwd_cnt;
    assign stall_cnt = r_stall_cnt;
`else
    assign fwd_cnt   = '0;
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_operand_bypass.sv
// tb/tb_operand_bypass.sv - randomized self-checking bench for operand_bypass against a stage-history model
module tb_operand_bypass;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;
    localparam int CNT_W  = 32;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [1:0]        reg_RD = '0;
    logic [REG_AW-1:0] rs1 = '0, rs2 = '0, rs3 = '0;
    logic              reg_WE = 1'b0, is_load = 1'b0, flush_in = 1'b0;
    logic [XLEN-1:0]   res_E = '0, res_M = '0, res_WB = '0, rf_rd1 = '0, rf_rd2 = '0;
    logic [XLEN-1:0]   op1, op2;
    logic [1:0]        fwd_sel1, fwd_sel2;
    logic              stall_FD, bubble_E;
    logic [CNT_W-1:0]  fwd_cnt, stall_cnt;

    operand_bypass #(.XLEN(XLEN), .REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .reg_RD(reg_RD), .rs1(rs1), .rs2(rs2), .rs3(rs3),
        .reg_WE(reg_WE), .is_load(is_load), .flush_in(flush_in),
        .res_E(res_E), .res_M(res_M), .res_WB(res_WB), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
        .op1(op1), .op2(op2), .fwd_sel1(fwd_sel1), .fwd_sel2(fwd_sel2),
        .stall_FD(stall_FD), .bubble_E(bubble_E), .fwd_cnt(fwd_cnt), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Model: history of instructions issued into E, index 0 = E, 1 = M, 2 = WB
    typedef struct {
        bit we;
        bit ld;
        int rd;
    } hist_t;

    hist_t       m_hist[3];
    int          m_fwd;
    int          m_stall;
    int          e_sel1, e_sel2;
    logic [31:0] e_op1, e_op2;
    bit          e_stall, e_bubble;

    task automatic model_reset();
        for (int k = 0; k < 3; k++) m_hist[k] = '{we: 0, ld: 0, rd: 0};
        m_fwd   = 0;
        m_stall = 0;
    endtask

    task automatic resolve(input int rs, input bit en, input logic [31:0] rf,
                           output int sel, output logic [31:0] op, output bit lu);
        logic [31:0] res[3];
        bit          found;
        res   = '{res_E, res_M, res_WB};
        sel   = 0;
        op    = rf;
        lu    = 0;
        found = 0;
        if (en && rs != 0) begin
            for (int k = 0; k < 3; k++) begin
                if (!found && m_hist[k].we && m_hist[k].rd == rs) begin
                    found = 1;
                    if (k == 0 && m_hist[k].ld) lu = 1;
                    else begin
                        sel = k + 1;
                        op  = res[k];
                    end
                end
            end
        end
    endtask

    // Predict and compare every output for the inputs currently applied
    task automatic check_cycle();
        bit lu1, lu2;
        resolve(int'(rs1), reg_RD[0], rf_rd1, e_sel1, e_op1, lu1);
        resolve(int'(rs2), reg_RD[1], rf_rd2, e_sel2, e_op2, lu2);
        e_stall  = (lu1 | lu2) & ~flush_in;
        e_bubble = lu1 | lu2 | flush_in;
        check("op1", op1, e_op1);
        check("op2", op2, e_op2);
        check("sel1", fwd_sel1, e_sel1);
        check("sel2", fwd_sel2, e_sel2);
        check("stall_FD", stall_FD, e_stall);
        check("bubble_E", bubble_E, e_bubble);
`ifdef BYPASS_PERF_EN
        check("fwd_cnt", fwd_cnt, m_fwd);
        check("stall_cnt", stall_cnt, m_stall);
`else
        check("fwd_cnt", fwd_cnt, 0);
        check("stall_cnt", stall_cnt, 0);
`endif
    endtask

    // Clock edge: history shifts; a killed or stalled decode instruction becomes an empty slot
    task automatic advance();
        @(posedge clk);
        if (e_sel1 != 0 || e_sel2 != 0) m_fwd++;
        if (e_stall) m_stall++;
        m_hist[2] = m_hist[1];
        m_hist[1] = m_hist[0];
        if (e_bubble) m_hist[0] = '{we: 0, ld: 0, rd: 0};
        else          m_hist[0] = '{we: reg_WE, ld: is_load, rd: int'(rs3)};
    endtask

    task automatic cyc(input logic [1:0] rdm, input int a, input int b, input int d,
                       input bit we, input bit ld, input bit fl);
        @(negedge clk);
        reg_RD = rdm; rs1 = a[4:0]; rs2 = b[4:0]; rs3 = d[4:0];
        reg_WE = we; is_load = ld; flush_in = fl;
        res_E = $urandom; res_M = $urandom; res_WB = $urandom;
        rf_rd1 = $urandom; rf_rd2 = $urandom;
        #1;
        check_cycle();
    endtask

    initial begin
        model_reset();
        rf_rd1 = 32'hdead_beef; rf_rd2 = 32'h1234_5678;
        reg_RD = 2'b11; flush_in = 1'b1;
        #2;
        check("rst_op1", op1, 0);
        check("rst_bubble", bubble_E, 0);
        check("rst_sel1", fwd_sel1, 0);
        @(negedge clk);
        reset = 1'b1;

        // add x5 ; add x6,x5
        cyc(2'b00, 0, 0, 5, 1, 0, 0); advance();
        cyc(2'b01, 5, 0, 6, 1, 0, 0);
        check("t1_sel1", fwd_sel1, 1);
        check("t1_op1", op1, res_E);
        advance();

        // lw x7 ; add x8,x7,x7 (stall then M forward)
        cyc(2'b00, 0, 0, 7, 1, 1, 0); advance();
        cyc(2'b11, 7, 7, 8, 1, 0, 0);
        check("t2_stall", stall_FD, 1);
        advance();
        cyc(2'b11, 7, 7, 8, 1, 0, 0);
        check("t2_sel2", fwd_sel2, 2);
        check("t2_op1", op1, res_M);
        advance();

        // x0 never forwards; x9 in E and M resolves to E
        cyc(2'b00, 0, 0, 0, 1, 0, 0); advance();
        cyc(2'b11, 0, 0, 9, 1, 0, 0);
        check("t3_x0_sel", fwd_sel1, 0);
        advance();
        cyc(2'b00, 0, 0, 9, 1, 0, 0); advance();
        cyc(2'b11, 9, 9, 1, 0, 0, 0);
        check("t3_x9_sel", fwd_sel1, 1);
        advance();

        // lw x3 in E with flush: flush wins, then x3 seen in M
        cyc(2'b00, 0, 0, 3, 1, 1, 0); advance();
        cyc(2'b01, 3, 0, 4, 1, 0, 1);
        check("t4_stall", stall_FD, 0);
        advance();
        cyc(2'b01, 3, 0, 4, 1, 0, 0);
        check("t4_sel1", fwd_sel1, 2);
        advance();

        // rs2 ignored when reg_RD=01
        cyc(2'b00, 0, 0, 12, 1, 0, 0); advance();
        cyc(2'b01, 1, 12, 2, 0, 0, 0);
        check("t6_sel2", fwd_sel2, 0);
        advance();

        // Reset asserted mid-stall
        cyc(2'b00, 0, 0, 7, 1, 1, 0); advance();
        cyc(2'b11, 7, 7, 8, 1, 0, 0);
        #1 reset = 1'b0;
        #1;
        check("t5_stall", stall_FD, 0);
        check("t5_sel1", fwd_sel1, 0);
        check("t5_fwd_cnt", fwd_cnt, 0);
        check("t5_stall_cnt", stall_cnt, 0);
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        cyc(2'b11, 7, 7, 8, 1, 0, 0);
        check("t5_post_sel2", fwd_sel2, 0);
        advance();

        // Random traffic over a small register window so hazards are frequent
        for (int i = 0; i < 400; i++) begin
            cyc(2'($urandom_range(0, 3)), $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(0, 3), ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0),
                ($urandom_range(0, 7) == 0));
            advance();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
